reg_bank_arbiter: RTL and testbench

//  Shares a bank of NUM_REGS 16-bit FunSel-controlled registers between two requesters.

---
 rtl/reg_bank_arbiter.sv | 122 ++++++++++++
 tb/tb_reg_bank_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing a FunSel-controlled register bank between an ALU
// writeback port (A) and an 8-bit load port (B) that can lock the bank for a two-beat word.
module reg_bank_arbiter #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                A_Req,
    input  logic [SEL_W-1:0]    A_Sel,
    input  logic [2:0]          A_Op,
    input  logic [15:0]         A_Data,
    output logic                A_Gnt,
    input  logic                B_Req,
    input  logic [SEL_W-1:0]    B_Sel,
    input  logic [7:0]          B_Byte,
    input  logic                B_Wide,
    input  logic                B_Sext,
    output logic                B_Gnt,
    output logic                B_Done,
    output logic [15:0]         I,
    output logic [2:0]          FunSel,
    output logic [NUM_REGS-1:0] E,
    output logic                Busy,
    output logic                Err
);

    localparam logic [2:0] FS_LOAD_LO_ZX = 3'b100;
    localparam logic [2:0] FS_LOAD_HI    = 3'b110;
    localparam logic [2:0] FS_LOAD_LO_SX = 3'b111;

    typedef enum logic {IDLE, B_HI} state_t;

    state_t           state;
    logic             prio_b;
    logic [SEL_W-1:0] hi_sel;
    logic             a_go;
    logic             b_go;

    function automatic logic sel_ok(input logic [SEL_W-1:0] sel);
        return 32'(sel) < NUM_REGS;
    endfunction

    // Out-of-range selects still get a grant; they simply enable no register.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] sel);
        return sel_ok(sel) ? (NUM_REGS'(1) << sel) : '0;
    endfunction

    assign a_go = A_Req && (!B_Req || !prio_b);
    assign b_go = B_Req && !a_go;

    // NOTE: every register here is assigned with <= so all outputs update together
    // from the pre-edge values; blocking assignments would let later lines see new state.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            prio_b <= 1'b0;
            hi_sel <= '0;
            A_Gnt  <= 1'b0;
            B_Gnt  <= 1'b0;
            B_Done <= 1'b0;
            Busy   <= 1'b0;
            Err    <= 1'b0;
            E      <= '0;
            FunSel <= 3'b000;
            I      <= 16'h0000;
        end else begin
            // Pulses and enables default low; FunSel and I keep their last values.
            A_Gnt  <= 1'b0;
            B_Gnt  <= 1'b0;
            B_Done <= 1'b0;
            Err    <= 1'b0;
            E      <= '0;

            case (state)
                IDLE: begin
                    if (a_go) begin
                        A_Gnt  <= 1'b1;
                        FunSel <= A_Op;
                        I      <= A_Data;
                        E      <= onehot(A_Sel);
                        Err    <= !sel_ok(A_Sel);
                        prio_b <= 1'b1;
                    end else if (b_go) begin
                        B_Gnt <= 1'b1;
                        I     <= {8'h00, B_Byte};
                        E     <= onehot(B_Sel);
                        Err   <= !sel_ok(B_Sel);
                        if (B_Wide) begin
                            FunSel <= FS_LOAD_LO_ZX;
                            hi_sel <= B_Sel;
                            Busy   <= 1'b1;
                            state  <= B_HI;
                        end else begin
                            FunSel <= B_Sext ? FS_LOAD_LO_SX : FS_LOAD_LO_ZX;
                            B_Done <= 1'b1;
                            prio_b <= 1'b0;
                        end
                    end
                end

                B_HI: begin
                    // Bank stays locked to B until the high byte arrives.
                    if (B_Req) begin
                        B_Gnt  <= 1'b1;
                        B_Done <= 1'b1;
                        FunSel <= FS_LOAD_HI;
                        I      <= {8'h00, B_Byte};
                        E      <= onehot(hi_sel);
                        Err    <= !sel_ok(hi_sel);
                        Busy   <= 1'b0;
                        prio_b <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: drives both ports and models the FunSel
// register bank so register contents can be checked against hand-computed values.
module tb_reg_bank_arbiter;

    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned SEL_W    = 3;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             A_Req;
    logic [SEL_W-1:0] A_Sel;
    logic [2:0]       A_Op;
    logic [15:0]      A_Data;
    logic             A_Gnt;
    logic             B_Req;
    logic [SEL_W-1:0] B_Sel;
    logic [7:0]       B_Byte;
    logic             B_Wide;
    logic             B_Sext;
    logic             B_Gnt;
    logic             B_Done;
    logic [15:0]      I;
    logic [2:0]       FunSel;
    logic [NUM_REGS-1:0] E;
    logic             Busy;
    logic             Err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] bank [NUM_REGS] = '{default: 16'h0000};

    reg_bank_arbiter #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) dut (
        .Clock(Clock), .Reset(Reset),
        .A_Req(A_Req), .A_Sel(A_Sel), .A_Op(A_Op), .A_Data(A_Data), .A_Gnt(A_Gnt),
        .B_Req(B_Req), .B_Sel(B_Sel), .B_Byte(B_Byte), .B_Wide(B_Wide), .B_Sext(B_Sext),
        .B_Gnt(B_Gnt), .B_Done(B_Done),
        .I(I), .FunSel(FunSel), .E(E), .Busy(Busy), .Err(Err)
    );

    always #5 Clock = ~Clock;

    // Bank model: the usual 16-bit FunSel register, qualified by E.
    always @(posedge Clock) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (E[r]) begin
                case (FunSel)
                    3'b000: bank[r] <= bank[r] - 16'd1;
                    3'b001: bank[r] <= bank[r] + 16'd1;
                    3'b010: bank[r] <= I;
                    3'b011: bank[r] <= 16'h0000;
                    3'b100: bank[r] <= {8'h00, I[7:0]};
                    3'b101: bank[r] <= {bank[r][15:8], I[7:0]};
                    3'b110: bank[r] <= {I[7:0], bank[r][7:0]};
                    3'b111: bank[r] <= {{8{I[7]}}, I[7:0]};
                    default: bank[r] <= bank[r];
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        A_Req = 1'b0; A_Sel = '0; A_Op = 3'b000; A_Data = 16'h0000;
        B_Req = 1'b0; B_Sel = '0; B_Byte = 8'h00; B_Wide = 1'b0; B_Sext = 1'b0;

        // 1. Reset state
        step(); step();
        Reset = 1'b1;
        step();
        check("rst_E", 32'(E), 32'h0);
        check("rst_AGnt", 32'(A_Gnt), 32'h0);
        check("rst_BGnt", 32'(B_Gnt), 32'h0);
        check("rst_Busy", 32'(Busy), 32'h0);
        check("rst_FunSel", 32'(FunSel), 32'h0);
        check("rst_I", 32'(I), 32'h0);

        // 2. Single A op: load R2
        A_Req = 1'b1; A_Sel = 3'd2; A_Op = 3'b010; A_Data = 16'hBEEF;
        step();
        check("a_gnt", 32'(A_Gnt), 32'h1);
        check("a_E", 32'(E), 32'h4);
        check("a_FunSel", 32'(FunSel), 32'h2);
        check("a_I", 32'(I), 32'hBEEF);
        check("a_Err", 32'(Err), 32'h0);
        A_Req = 1'b0;
        step();
        check("a_R2", 32'(bank[2]), 32'hBEEF);
        check("a_gnt_drop", 32'(A_Gnt), 32'h0);
        check("a_E_idle", 32'(E), 32'h0);

        // 3. B word to R1 with a one-cycle stall between beats
        B_Req = 1'b1; B_Wide = 1'b1; B_Sel = 3'd1; B_Byte = 8'h34;
        step();
        check("w1_gnt", 32'(B_Gnt), 32'h1);
        check("w1_done", 32'(B_Done), 32'h0);
        check("w1_FunSel", 32'(FunSel), 32'h4);
        check("w1_I", 32'(I), 32'h0034);
        check("w1_E", 32'(E), 32'h2);
        check("w1_Busy", 32'(Busy), 32'h1);
        B_Req = 1'b0; B_Byte = 8'h12; B_Sel = 3'd3;
        step();
        check("wst_E", 32'(E), 32'h0);
        check("wst_Busy", 32'(Busy), 32'h1);
        check("wst_R1", 32'(bank[1]), 32'h0034);
        B_Req = 1'b1;
        step();
        check("w2_gnt", 32'(B_Gnt), 32'h1);
        check("w2_done", 32'(B_Done), 32'h1);
        check("w2_FunSel", 32'(FunSel), 32'h6);
        check("w2_E_latched", 32'(E), 32'h2);
        check("w2_Busy", 32'(Busy), 32'h0);
        B_Req = 1'b0; B_Wide = 1'b0;
        step();
        check("w_R1", 32'(bank[1]), 32'h1234);

        // 4. Both held: A,B,A then B word with a 3-cycle stall, then A
        A_Req = 1'b1; A_Sel = 3'd0; A_Op = 3'b010; A_Data = 16'h1111;
        B_Req = 1'b1; B_Wide = 1'b0; B_Sext = 1'b0; B_Sel = 3'd3; B_Byte = 8'h55;
        step();
        check("rr1_A", 32'({A_Gnt, B_Gnt}), 32'h2);
        check("rr1_E", 32'(E), 32'h1);
        step();
        check("rr2_B", 32'({A_Gnt, B_Gnt, B_Done}), 32'h3);
        check("rr2_E", 32'(E), 32'h8);
        B_Wide = 1'b1;
        step();
        check("rr3_A", 32'({A_Gnt, B_Gnt}), 32'h2);
        step();
        check("rr4_Bw", 32'({A_Gnt, B_Gnt, B_Done}), 32'h2);
        check("rr4_Busy", 32'(Busy), 32'h1);
        B_Req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("rr_hold_AGnt", 32'(A_Gnt), 32'h0);
            check("rr_hold_E", 32'(E), 32'h0);
            check("rr_hold_Busy", 32'(Busy), 32'h1);
        end
        B_Req = 1'b1;
        step();
        check("rr8_B2", 32'({A_Gnt, B_Gnt, B_Done}), 32'h3);
        step();
        check("rr9_A", 32'({A_Gnt, B_Gnt}), 32'h2);
        A_Req = 1'b0; B_Req = 1'b0; B_Wide = 1'b0;
        step();
        check("rr_R3", 32'(bank[3]), 32'h5555);

        // 5. Byte loads to R0: sign- and zero-extended
        B_Req = 1'b1; B_Sel = 3'd0; B_Byte = 8'h80; B_Sext = 1'b1;
        step();
        check("sx_FunSel", 32'(FunSel), 32'h7);
        check("sx_E", 32'(E), 32'h1);
        check("sx_done", 32'(B_Done), 32'h1);
        B_Req = 1'b0;
        step();
        check("sx_R0", 32'(bank[0]), 32'hFF80);
        B_Req = 1'b1; B_Sext = 1'b0;
        step();
        check("zx_FunSel", 32'(FunSel), 32'h4);
        B_Req = 1'b0;
        step();
        check("zx_R0", 32'(bank[0]), 32'h0080);

        // 6a. Out-of-range select
        A_Req = 1'b1; A_Sel = 3'd5; A_Op = 3'b010; A_Data = 16'hDEAD;
        step();
        check("oor_gnt", 32'(A_Gnt), 32'h1);
        check("oor_Err", 32'(Err), 32'h1);
        check("oor_E", 32'(E), 32'h0);
        A_Req = 1'b0;
        step();
        check("oor_Err_drop", 32'(Err), 32'h0);
        check("oor_R0", 32'(bank[0]), 32'h0080);
        check("oor_R1", 32'(bank[1]), 32'h1234);
        check("oor_R2", 32'(bank[2]), 32'hBEEF);
        check("oor_R3", 32'(bank[3]), 32'h5555);

        // 6b. Reset pulse while locked in B_HI
        B_Req = 1'b1; B_Wide = 1'b1; B_Sel = 3'd2; B_Byte = 8'hAA;
        step();
        check("rb_Busy", 32'(Busy), 32'h1);
        B_Req = 1'b0; B_Wide = 1'b0;
        step();
        Reset = 1'b0;
        #2;
        check("rb_Busy_clr", 32'(Busy), 32'h0);
        check("rb_E_clr", 32'(E), 32'h0);
        Reset = 1'b1;
        check("rb_R2_partial", 32'(bank[2]), 32'h00AA);
        A_Req = 1'b1; A_Sel = 3'd1; A_Op = 3'b001;
        step();
        check("rb_idle_AGnt", 32'(A_Gnt), 32'h1);
        check("rb_idle_E", 32'(E), 32'h2);
        A_Req = 1'b0;
        step();
        check("rb_R1_inc", 32'(bank[1]), 32'h1235);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
